// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;
  localparam int unsigned PC_STEP = 4;

  function automatic logic is_halt_op(input logic [5:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating counters for accepted transfers and backpressure cycles.
module fetch_perf_counters (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        accept_i,
  input  logic        stall_i,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
);

  logic [31:0] fetch_count_q;
  logic [31:0] fetch_count_d;
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  // Next-state: increment on event, stick at all-ones.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (accept_i && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (stall_i && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign stall_count_o = stall_count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, output register and valid/ready handoff to decode.
// Define FETCH_PERF_CNT_EN to add the fetch_count/stall_count outputs.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                  halted_q;

  // Next-state and datapath: redirect beats load, load beats hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc & ALIGN_MASK;
          if_valid_d = 1'b0;
        end else if (!if_valid_q || if_ready) begin
          if_instr_d = i_read_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          // A halt word is still delivered; only the PC stops advancing.
          if (is_halt_op(i_read_data[DATA_WIDTH-1 -: 6])) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end else begin
          if_valid_d = if_valid_q;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc & ALIGN_MASK;
          if_valid_d = 1'b0;
          state_d    = ST_RUN;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
        end else begin
          if_valid_d = if_valid_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any in-flight transfer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      halted_q   <= (state_d == ST_HALT);
    end
  end

  assign i_address = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign halted    = halted_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clock         (clock),
    .reset_n       (reset_n),
    .accept_i      (if_valid_q && if_ready),
    .stall_i       (if_valid_q && !if_ready),
    .fetch_count_o (fetch_count),
    .stall_count_o (stall_count)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a combinational RAM model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] i_address;
  logic [31:0] i_read_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic halt_en;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } xfer_t;
  xfer_t exp_q[$];

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .i_address      (i_address),
    .i_read_data    (i_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // RAM contents: address-tagged words, plus a halt word at 0x000C when enabled.
  function automatic logic [31:0] mem_word(input logic [15:0] a, input logic h);
    if (h && (a == 16'h000C)) return 32'hFC00_0000;
    else return {16'hA000, a};
  endfunction

  always_comb i_read_data = mem_word(i_address, halt_en);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] pc);
    xfer_t e;
    e.pc    = pc;
    e.instr = mem_word(pc, halt_en);
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  xfer_t got_e;
  always @(negedge clock) begin
    if (if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL xfer_unexpected: got pc %h instr %h expected none", if_pc, if_instr);
      end else begin
        got_e = exp_q.pop_front();
        check("xfer_pc", {16'h0, if_pc}, {16'h0, got_e.pc});
        check("xfer_instr", if_instr, got_e.instr);
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    if_ready = 1'b1; halt_en = 1'b0;
    step(); step();
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_addr", {16'h0, i_address}, 32'h0);
    check("rst_if_pc", {16'h0, if_pc}, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_count, 32'h0);
    check("rst_stall_cnt", stall_count, 32'h0);
`endif
    // IDLE ignores redirect
    reset_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    check("idle_addr", {16'h0, i_address}, 32'h0);
    check("idle_valid", {31'h0, if_valid}, 32'h0);
    // start and streaming
    start = 1'b1; step(); start = 1'b0;
    check("run_addr0", {16'h0, i_address}, 32'h0);
    check("run_valid0", {31'h0, if_valid}, 32'h0);
    push(16'h0000); step();
    check("first_valid", {31'h0, if_valid}, 32'h1);
    check("first_if_pc", {16'h0, if_pc}, 32'h0);
    check("addr_4", {16'h0, i_address}, 32'h4);
    step();
    check("second_if_pc", {16'h0, if_pc}, 32'h4);
    check("addr_8", {16'h0, i_address}, 32'h8);
    // backpressure for 3 cycles
    if_ready = 1'b0;
    repeat (3) step();
    check("stall_if_pc", {16'h0, if_pc}, 32'h4);
    check("stall_instr", if_instr, 32'hA000_0004);
    check("stall_addr", {16'h0, i_address}, 32'h8);
    check("stall_valid", {31'h0, if_valid}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt3", stall_count, 32'h3);
`endif
    push(16'h0004); if_ready = 1'b1; step();
    check("resume_if_pc", {16'h0, if_pc}, 32'h8);
    check("addr_c", {16'h0, i_address}, 32'hC);
    // redirect with simultaneous accept: transfer completes, register flushes
    push(16'h0008); redirect_valid = 1'b1; redirect_pc = 16'h0102; step();
    redirect_valid = 1'b0;
    check("redir_flush", {31'h0, if_valid}, 32'h0);
    check("redir_addr", {16'h0, i_address}, 32'h100);
    push(16'h0100); step();
    check("redir_if_pc", {16'h0, if_pc}, 32'h100);
    check("redir_valid", {31'h0, if_valid}, 32'h1);
    check("redir_next", {16'h0, i_address}, 32'h104);
    // halt word at 0x000C
    halt_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0004; step();
    redirect_valid = 1'b0;
    push(16'h0004); push(16'h0008); push(16'h000C);
    step(); step(); step();
    check("halt_if_pc", {16'h0, if_pc}, 32'hC);
    check("halt_instr", if_instr, 32'hFC00_0000);
    check("halt_flag", {31'h0, halted}, 32'h1);
    check("halt_addr", {16'h0, i_address}, 32'hC);
    start = 1'b1; step(); start = 1'b0;
    check("halt_drain", {31'h0, if_valid}, 32'h0);
    check("halt_addr_hold", {16'h0, i_address}, 32'hC);
    step();
    check("halt_no_fetch", {31'h0, if_valid}, 32'h0);
    check("halt_start_ign", {31'h0, halted}, 32'h1);
    push(16'h0000); redirect_valid = 1'b1; redirect_pc = 16'h0000; step();
    redirect_valid = 1'b0;
    check("resume_halted", {31'h0, halted}, 32'h0);
    check("resume_addr", {16'h0, i_address}, 32'h0);
    step();
    check("resume_fetch_pc", {16'h0, if_pc}, 32'h0);
    check("resume_fetch_v", {31'h0, if_valid}, 32'h1);
    // wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC; step();
    redirect_valid = 1'b0;
    check("wrap_target", {16'h0, i_address}, 32'hFFFC);
    step();
    check("wrap_if_pc", {16'h0, if_pc}, 32'hFFFC);
    check("wrap_addr", {16'h0, i_address}, 32'h0);
    // reset while holding a stalled instruction
    if_ready = 1'b0; reset_n = 1'b0; step();
    check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    check("mid_rst_addr", {16'h0, i_address}, 32'h0);
    check("mid_rst_halted", {31'h0, halted}, 32'h0);
    check("mid_rst_if_pc", {16'h0, if_pc}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst_fcnt", fetch_count, 32'h0);
    check("mid_rst_scnt", stall_count, 32'h0);
`endif
    reset_n = 1'b1; if_ready = 1'b1; step(); step();
    check("post_rst_idle", {31'h0, if_valid}, 32'h0);
    check("post_rst_addr", {16'h0, i_address}, 32'h0);
    push(16'h0000); start = 1'b1; step(); start = 1'b0; step();
    check("restart_if_pc", {16'h0, if_pc}, 32'h0);
    check("restart_valid", {31'h0, if_valid}, 32'h1);
    step();
    if_ready = 1'b0; step();
    check("final_if_pc", {16'h0, if_pc}, 32'h4);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("final_fcnt", fetch_count, 32'h1);
    check("final_scnt", stall_count, 32'h1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage that sits directly upstream of the dual-port `ram` instruction port. It holds the program counter and drives `i_address`. It captures the instruction that `ram` returns combinationally on `i_read_data` into an output register, and hands that register to decode over a valid/ready handshake. It supports branch redirect, backpressure and a halt opcode.

## Interface
- `DATA_WIDTH`, 32, instruction width; matches `ram`.
- `ADDR_WIDTH`, 16, byte address width; matches `ram`.
- `RESET_PC`, 0, PC loaded at reset; must be a multiple of 4.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; moves IDLE to RUN.
- `i_address`  out  ADDR_WIDTH  to `ram` `i_address`; always equals the PC register.
- `i_read_data`  in  DATA_WIDTH  from `ram` `i_read_data`; valid in the same cycle as `i_address`.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  ADDR_WIDTH  target byte address.
- `if_valid`  out  1  output register holds an instruction.
- `if_ready`  in  1  decode accepts this cycle.
- `if_instr`  out  DATA_WIDTH  fetched instruction.
- `if_pc`  out  ADDR_WIDTH  address of `if_instr`.
- `halted`  out  1  state is HALT.

## Operation
- Reset (`reset_n`=0 at the edge) sets:
  - state to IDLE and `pc` to RESET_PC;
  - `if_valid`, `if_instr`, `if_pc` and `halted` to 0;
  - counters to 0.
- Reset has priority over every other input, including mid-transfer.
- IDLE:
  - No loads.
  - `start` goes to RUN.
  - `redirect_valid` is ignored.
- RUN, in priority order:
  1. `redirect_valid`=1:
     - `pc` ← {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00} (forced word alignment).
     - `if_valid` ← 0, whether or not `if_ready` is high. This flushes the output.
     - No load this cycle.
  2. Load when `!if_valid || if_ready`:
     - `if_instr` ← `i_read_data`, `if_pc` ← `pc`, `if_valid` ← 1.
     - If `i_read_data`[31:26] == HALT_OPCODE (6'h3F): state ← HALT and `pc` holds.
     - Otherwise `pc` ← `pc` + 4, wrapping modulo 2^ADDR_WIDTH.
  3. Otherwise the output register holds (`if_valid` && !`if_ready`) and `pc` holds.
- HALT:
  - No loads. `pc` holds.
  - `if_valid` clears when the halt instruction is accepted (`if_ready`=1).
  - `redirect_valid` applies the redirect and flush, and returns to RUN.
  - `start` is ignored.
- `if_instr`/`if_pc` keep their last value when `if_valid`=0.

## Timing
- Fetch latency: `if_valid` rises 1 cycle after the PC appears on `i_address`.
- The first instruction is valid 2 edges after the `start` edge.
- Throughput: one instruction per cycle while `if_ready`=1.
- Redirect penalty: 1 bubble cycle. The target instruction is valid on the edge after the redirect edge plus one.
- While `if_valid`=1 and `if_ready`=0, `if_instr`, `if_pc` and `i_address` are stable.
- `redirect_valid` and `if_ready` in the same cycle: the transfer completes at decode and the register is still flushed.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds two outputs:
  - `fetch_count` [31:0]: increments on every accepted transfer (`if_valid` && `if_ready`).
  - `stall_count` [31:0]: increments on every cycle with `if_valid` && !`if_ready`.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Without the macro, the ports and logic are absent. Fetch behaviour is identical either way.

## Structure
- Package `fetch_pkg`:
  - state encoding IDLE=2'd0, RUN=2'd1, HALT=2'd2;
  - `HALT_OPCODE`=6'h3F;
  - `PC_STEP`=4.
- Sub-module `fetch_perf_counters` holds the two saturating counters. It is instantiated only under `FETCH_PERF_CNT_EN`.

## Test plan
- Preload RAM with words at 0x0, 0x4 and 0x8; reset; pulse `start`; hold `if_ready`=1.
  - `i_address` steps 0x0, 0x4, 0x8 on consecutive cycles.
  - `if_pc` follows one cycle later, with the matching `if_instr`.
- Drop `if_ready` for 3 cycles while `if_pc`=0x4.
  - `if_instr`/`if_pc` and `i_address`=0x8 hold.
  - `stall_count`=3 when the macro is enabled.
- Redirect to 0x0102 while `if_valid`=1.
  - Next cycle `if_valid`=0 and `i_address`=0x0100.
  - The following cycle `if_pc`=0x0100.
- Place 0xFC000000 at 0x000C.
  - The word is delivered, then `halted`=1 and `i_address` stays 0x000C.
  - No further `if_valid` after acceptance.
  - A redirect to 0x0 resumes fetching.
- Redirect to 0xFFFC.
  - The next fetch address is 0x0000 (wrap).
- Assert `reset_n`=0 while `if_valid`=1 and `if_ready`=0.
  - Next cycle `if_valid`=0, `i_address`=RESET_PC, state IDLE.
  - No fetch until `start`.
